vga_grid_ctrl: RTL and testbench
================================

VGA_GRID_CTRL -- requirements
Module: vga_grid_ctrl

Interface
REQ-001 SHALL expose ports: clk, input, 1, system clock (50 MHz).
REQ-002 SHALL expose: reset, input, 1, synchronous active-high reset.
REQ-003 SHALL expose: wr_req, input, 1, requester asks to write one cell colour; held high until wr_ack.
REQ-004 SHALL expose: wr_addr, input, 4, cell index to write, {row, col}.
REQ-005 SHALL expose: wr_color, input, 3, RGB colour for the cell.
REQ-006 SHALL expose: wr_ack, output, 1, one-clk pulse when the write has been committed.
REQ-007 SHALL expose: busy, output, 1, write latched and not yet acknowledged.
REQ-008 SHALL expose: hsync, output, 1, active-low horizontal sync.
REQ-009 SHALL expose: vsync, output, 1, active-low vertical sync.
REQ-010 SHALL expose: video_on, output, 1, high inside the 640x480 visible area.
REQ-011 SHALL expose: x_pos, output, 10, current pixel column, 0-799.
REQ-012 SHALL expose: y_pos, output, 10, current line, 0-524.
REQ-013 SHALL expose: cell_idx, output, 4, grid cell of the current pixel.
REQ-014 SHALL expose: rgb, output, 3, pixel colour.
REQ-015 Clocking: one clock; reset is synchronous and active-high.

Function
REQ-016 Pixel tick SHALL toggle every clk from 0 after reset; counters advance only on clks where tick=1 (25 MHz pixel rate).
REQ-017 x_pos SHALL count 0-799 and wrap to 0; y_pos SHALL increment when x_pos wraps, counting 0-524 and wrapping to 0.
REQ-018 hsync SHALL be 0 for x_pos 656-751 inclusive; vsync SHALL be 0 for y_pos 490-491 inclusive; both 1 otherwise.
REQ-019 video_on SHALL be 1 only when x_pos<640 and y_pos<480.
REQ-020 cell_idx SHALL be {row, col}: col = 0/1/2/3 for x_pos <160/<320/<480/else; row = 0/1/2/3 for y_pos <120/<240/<360/else.
REQ-021 hsync, vsync, video_on, cell_idx and rgb SHALL be registered from the next counter values, so they stay aligned with x_pos/y_pos, with no extra latency.
REQ-022 rgb SHALL be colour[cell_idx] when video_on=1, else 3'b000.
REQ-023 The colour store SHALL hold 16 x 3-bit entries, written only through the handshake.
REQ-024 Write FSM states: IDLE, WAIT_VB, ACK.
REQ-025 IDLE: on wr_req=1, latch wr_addr/wr_color, go to WAIT_VB, and set busy=1.
REQ-026 WAIT_VB: on the first clk with y_pos>=480, write the entry and go to ACK.
REQ-027 WAIT_VB: if a write is latched while already in vertical blank, commit on the next clk.
REQ-028 ACK: wr_ack=1 for exactly one clk, busy=0, then go to IDLE.
REQ-029 A new request SHALL NOT be latched before the clk after ACK.
REQ-030 wr_addr/wr_color changes while busy=1 SHALL be ignored.
REQ-031 Visible pixels SHALL never show a partially written frame; commits occur only during lines 480-524.

Reset
REQ-032 While reset=1, SHALL set x_pos=0, y_pos=0, tick=0, hsync=1, vsync=1, video_on=0, cell_idx=0, rgb=0, all colours=0, FSM=IDLE, busy=0, wr_ack=0.
REQ-033 video_on and rgb SHALL stay 0 until the first counter advance after reset release.
REQ-034 Reset mid-write SHALL discard the pending write with no wr_ack.

Configuration
REQ-035 Macro GRID_BORDER_EN defined: while video_on=1 and x_pos is one of {0,160,320,480,639} or y_pos is one of {0,120,240,360,479}, rgb SHALL be 3'b111.
REQ-036 GRID_BORDER_EN undefined: rgb SHALL follow REQ-022 only, with no extra logic.

Verification
REQ-037 Run a full frame after reset: hsync low 96 ticks per line starting at x_pos=656; vsync low on lines 490-491; frame = 840000 clks.
REQ-038 Write addr=5, colour=3'b100 at y_pos=100: wr_ack stays 0 until y_pos reaches 480; pixel (200,150) shows 000 this frame and 100 next frame.
REQ-039 wr_req raised at y_pos=500: commit and wr_ack within 2 clks; busy falls with wr_ack.
REQ-040 Boundary mapping: x=159,y=0 gives cell_idx 0; x=160,y=0 gives 1; x=639,y=479 gives 15; x=640 gives video_on=0 and rgb=0.
REQ-041 Assert reset in WAIT_VB: no wr_ack, busy=0, all colours 0, counters restart at 0,0.
REQ-042 With all colours 3'b010, check x=160,y=50: rgb=111 with GRID_BORDER_EN defined, 010 without it.

Source files
------------

// File: rtl/vga_grid_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : vga_grid_ctrl_if
// Description : Cell-colour write handshake between a requester and
//               vga_grid_ctrl (request/address/colour in, ack/busy out).
// Revision    : 1.0 - initial release
// ============================================================================
interface vga_grid_ctrl_if;
    logic       wr_req;
    logic [3:0] wr_addr;
    logic [2:0] wr_color;
    logic       wr_ack;
    logic       busy;

    // Requester side
    modport master (
        output wr_req,
        output wr_addr,
        output wr_color,
        input  wr_ack,
        input  busy
    );

    // Controller side
    modport slave (
        input  wr_req,
        input  wr_addr,
        input  wr_color,
        output wr_ack,
        output busy
    );
endinterface
`default_nettype wire

// File: rtl/vga_grid_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : vga_grid_ctrl
// Description : 640x480@60 VGA timing generator driving a 4x4 grid of cells.
//               Each cell colour lives in a 16x3-bit store that is written
//               through a req/ack handshake; commits are deferred to vertical
//               blank so a visible frame is never partially updated.
//               Optional macro GRID_BORDER_EN paints cell borders white.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_grid_ctrl #(
    parameter int H_VISIBLE    = 640,
    parameter int H_SYNC_START = 656,
    parameter int H_SYNC_END   = 751,
    parameter int H_TOTAL      = 800,
    parameter int V_VISIBLE    = 480,
    parameter int V_SYNC_START = 490,
    parameter int V_SYNC_END   = 491,
    parameter int V_TOTAL      = 525
) (
    input  wire logic        clk,
    input  wire logic        reset,
    vga_grid_ctrl_if.slave   wr,
    output logic             hsync,
    output logic             vsync,
    output logic             video_on,
    output logic [9:0]       x_pos,
    output logic [9:0]       y_pos,
    output logic [3:0]       cell_idx,
    output logic [2:0]       rgb
);
    localparam logic [9:0] c_h_max    = 10'(H_TOTAL - 1);
    localparam logic [9:0] c_v_max    = 10'(V_TOTAL - 1);
    localparam logic [9:0] c_h_vis    = 10'(H_VISIBLE);
    localparam logic [9:0] c_v_vis    = 10'(V_VISIBLE);
    localparam logic [9:0] c_hs_start = 10'(H_SYNC_START);
    localparam logic [9:0] c_hs_end   = 10'(H_SYNC_END);
    localparam logic [9:0] c_vs_start = 10'(V_SYNC_START);
    localparam logic [9:0] c_vs_end   = 10'(V_SYNC_END);
    localparam logic [9:0] c_col_1    = 10'(H_VISIBLE / 4);
    localparam logic [9:0] c_col_2    = 10'(2 * (H_VISIBLE / 4));
    localparam logic [9:0] c_col_3    = 10'(3 * (H_VISIBLE / 4));
    localparam logic [9:0] c_row_1    = 10'(V_VISIBLE / 4);
    localparam logic [9:0] c_row_2    = 10'(2 * (V_VISIBLE / 4));
    localparam logic [9:0] c_row_3    = 10'(3 * (V_VISIBLE / 4));

    localparam logic [1:0] c_st_idle    = 2'd0;
    localparam logic [1:0] c_st_wait_vb = 2'd1;
    localparam logic [1:0] c_st_ack     = 2'd2;

    logic       r_tick;
    logic [1:0] r_state;
    logic [3:0] r_lat_addr;
    logic [2:0] r_lat_color;
    logic [2:0] r_colors [16];

    logic [9:0] w_x_next;
    logic [9:0] w_y_next;
    logic [1:0] w_col_next;
    logic [1:0] w_row_next;
    logic [3:0] w_cell_next;
    logic       w_vis_next;
    logic       w_hs_next;
    logic       w_vs_next;
    logic [2:0] w_rgb_next;
    logic       w_commit;

    // Position after the next pixel advance (only consumed on tick clocks)
    always_comb begin
        w_x_next = x_pos + 10'd1;
        w_y_next = y_pos;
        if (x_pos == c_h_max) begin
            w_x_next = 10'd0;
            w_y_next = (y_pos == c_v_max) ? 10'd0 : y_pos + 10'd1;
        end
    end

    // Grid column/row of the next pixel; last column/row absorbs the remainder
    always_comb begin
        if (w_x_next < c_col_1)      w_col_next = 2'd0;
        else if (w_x_next < c_col_2) w_col_next = 2'd1;
        else if (w_x_next < c_col_3) w_col_next = 2'd2;
        else                         w_col_next = 2'd3;
        if (w_y_next < c_row_1)      w_row_next = 2'd0;
        else if (w_y_next < c_row_2) w_row_next = 2'd1;
        else if (w_y_next < c_row_3) w_row_next = 2'd2;
        else                         w_row_next = 2'd3;
    end

    assign w_cell_next = {w_row_next, w_col_next};
    assign w_vis_next  = (w_x_next < c_h_vis) && (w_y_next < c_v_vis);
    assign w_hs_next   = !((w_x_next >= c_hs_start) && (w_x_next <= c_hs_end));
    assign w_vs_next   = !((w_y_next >= c_vs_start) && (w_y_next <= c_vs_end));

`ifdef GRID_BORDER_EN
    localparam logic [9:0] c_h_last = 10'(H_VISIBLE - 1);
    localparam logic [9:0] c_v_last = 10'(V_VISIBLE - 1);
    logic w_border_next;

    // Pixel lies on a cell boundary line or the outer right/bottom edge
    always_comb begin
        w_border_next = (w_x_next == 10'd0)   || (w_x_next == c_col_1) ||
                        (w_x_next == c_col_2) || (w_x_next == c_col_3) ||
                        (w_x_next == c_h_last) ||
                        (w_y_next == 10'd0)   || (w_y_next == c_row_1) ||
                        (w_y_next == c_row_2) || (w_y_next == c_row_3) ||
                        (w_y_next == c_v_last);
    end

    assign w_rgb_next = !w_vis_next   ? 3'b000 :
                        w_border_next ? 3'b111 : r_colors[w_cell_next];
`else
    assign w_rgb_next = w_vis_next ? r_colors[w_cell_next] : 3'b000;
`endif

    // Pixel tick and counters; display outputs move together with the counters
    always_ff @(posedge clk) begin
        if (reset) begin
            r_tick   <= 1'b0;
            x_pos    <= 10'd0;
            y_pos    <= 10'd0;
            hsync    <= 1'b1;
            vsync    <= 1'b1;
            video_on <= 1'b0;
            cell_idx <= 4'd0;
            rgb      <= 3'b000;
        end else begin
            r_tick <= ~r_tick;
            if (r_tick) begin
                x_pos    <= w_x_next;
                y_pos    <= w_y_next;
                hsync    <= w_hs_next;
                vsync    <= w_vs_next;
                video_on <= w_vis_next;
                cell_idx <= w_cell_next;
                rgb      <= w_rgb_next;
            end
        end
    end

    // A latched write is committed on any clk spent in vertical blank
    assign w_commit = (r_state == c_st_wait_vb) && (y_pos >= c_v_vis);

    // Write handshake: latch in IDLE, wait for blank, one-clk acknowledge
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= c_st_idle;
            r_lat_addr  <= 4'd0;
            r_lat_color <= 3'b000;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (wr.wr_req) begin
                        r_lat_addr  <= wr.wr_addr;
                        r_lat_color <= wr.wr_color;
                        r_state     <= c_st_wait_vb;
                    end
                end
                c_st_wait_vb: begin
                    if (w_commit) begin
                        r_state <= c_st_ack;
                    end
                end
                c_st_ack: begin
                    r_state <= c_st_idle;
                end
                default: begin
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

    // Colour store, cleared by reset and written only on commit
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 16; i++) begin
                r_colors[i] <= 3'b000;
            end
        end else if (w_commit) begin
            r_colors[r_lat_addr] <= r_lat_color;
        end
    end

    assign wr.busy   = (r_state == c_st_wait_vb);
    assign wr.wr_ack = (r_state == c_st_ack);

endmodule
`default_nettype wire

// File: tb/tb_vga_grid_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_vga_grid_ctrl
// Description : Bench for vga_grid_ctrl. Instance 0 uses the full 640x480
//               timing; instance 1 uses a shrunken timing so many whole
//               frames and vertical blanks fit in a short run. Both are
//               compared each clk against a position-from-clock-count model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_grid_ctrl;
    localparam int P_HV  [2] = '{640, 16};
    localparam int P_HSS [2] = '{656, 20};
    localparam int P_HSE [2] = '{751, 23};
    localparam int P_HT  [2] = '{800, 28};
    localparam int P_VV  [2] = '{480, 12};
    localparam int P_VSS [2] = '{490, 14};
    localparam int P_VSE [2] = '{491, 15};
    localparam int P_VT  [2] = '{525, 17};

`ifdef GRID_BORDER_EN
    localparam logic [2:0] C_BORDER_EXP = 3'b111;
`else
    localparam logic [2:0] C_BORDER_EXP = 3'b010;
`endif

    logic clk = 1'b0;
    logic [1:0] rst;
    logic [1:0] hs, vs, von;
    logic [1:0][9:0] xp, yp;
    logic [1:0][3:0] ci;
    logic [1:0][2:0] rg;

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;
    logic run_cmp = 1'b0;

    vga_grid_ctrl_if wr0 ();
    vga_grid_ctrl_if wr1 ();

    always #10 clk = ~clk;

    vga_grid_ctrl dut_full (
        .clk(clk), .reset(rst[0]), .wr(wr0),
        .hsync(hs[0]), .vsync(vs[0]), .video_on(von[0]),
        .x_pos(xp[0]), .y_pos(yp[0]), .cell_idx(ci[0]), .rgb(rg[0])
    );

    vga_grid_ctrl #(
        .H_VISIBLE(16), .H_SYNC_START(20), .H_SYNC_END(23), .H_TOTAL(28),
        .V_VISIBLE(12), .V_SYNC_START(14), .V_SYNC_END(15), .V_TOTAL(17)
    ) dut_small (
        .clk(clk), .reset(rst[1]), .wr(wr1),
        .hsync(hs[1]), .vsync(vs[1]), .video_on(von[1]),
        .x_pos(xp[1]), .y_pos(yp[1]), .cell_idx(ci[1]), .rgb(rg[1])
    );

    // ---------------- behavioural model ----------------
    int         m_n    [2];        // clocks since reset release
    logic       m_pend [2];
    logic [3:0] m_addr [2];
    logic [2:0] m_col  [2];
    logic       m_ack  [2];
    logic [2:0] m_rgb  [2];
    logic [2:0] m_mem  [2][16];

    logic [1:0]      req;
    logic [1:0][3:0] req_addr;
    logic [1:0][2:0] req_col;
    assign req[0] = wr0.wr_req;  assign req_addr[0] = wr0.wr_addr;  assign req_col[0] = wr0.wr_color;
    assign req[1] = wr1.wr_req;  assign req_addr[1] = wr1.wr_addr;  assign req_col[1] = wr1.wr_color;

    function automatic int xof(input int k, input int n);
        int p;
        p = (n / 2) % (P_HT[k] * P_VT[k]);
        return p % P_HT[k];
    endfunction

    function automatic int yof(input int k, input int n);
        int p;
        p = (n / 2) % (P_HT[k] * P_VT[k]);
        return p / P_HT[k];
    endfunction

    function automatic logic [3:0] cellof(input int k, input int x, input int y);
        int col, row;
        col = x / (P_HV[k] / 4);
        row = y / (P_VV[k] / 4);
        if (col > 3) col = 3;
        if (row > 3) row = 3;
        return 4'(row * 4 + col);
    endfunction

    function automatic logic visof(input int k, input int x, input int y);
        return (x < P_HV[k]) && (y < P_VV[k]);
    endfunction

`ifdef GRID_BORDER_EN
    function automatic logic bordof(input int k, input int x, input int y);
        int w, h;
        w = P_HV[k] / 4;
        h = P_VV[k] / 4;
        return ((x % w == 0) && (x <= 3 * w)) || (x == P_HV[k] - 1) ||
               ((y % h == 0) && (y <= 3 * h)) || (y == P_VV[k] - 1);
    endfunction
`endif

    function automatic logic [2:0] pixof(input int k, input int x, input int y);
        if (!visof(k, x, y)) return 3'b000;
`ifdef GRID_BORDER_EN
        if (bordof(k, x, y)) return 3'b111;
`endif
        return m_mem[k][cellof(k, x, y)];
    endfunction

    // Model update: position is purely a function of clocks since reset
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (rst[k]) begin
                m_n[k]    <= 0;
                m_pend[k] <= 1'b0;
                m_ack[k]  <= 1'b0;
                m_rgb[k]  <= 3'b000;
                for (int j = 0; j < 16; j++) m_mem[k][j] <= 3'b000;
            end else begin
                m_n[k] <= m_n[k] + 1;
                if ((m_n[k] + 1) % 2 == 0)
                    m_rgb[k] <= pixof(k, xof(k, m_n[k] + 1), yof(k, m_n[k] + 1));
                if (m_ack[k]) begin
                    m_ack[k] <= 1'b0;
                end else if (m_pend[k]) begin
                    if (yof(k, m_n[k]) >= P_VV[k]) begin
                        m_mem[k][m_addr[k]] <= m_col[k];
                        m_pend[k] <= 1'b0;
                        m_ack[k]  <= 1'b1;
                    end
                end else if (req[k]) begin
                    m_pend[k] <= 1'b1;
                    m_addr[k] <= req_addr[k];
                    m_col[k]  <= req_col[k];
                end
            end
        end
    end

    // ---------------- checking ----------------
    task automatic summary();
        $display("%0d/%0d checks passed", n_pass, n_chk);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
            if (n_fail >= 50) begin
                summary();
                $finish;
            end
        end
    endtask

    int   cyc = 0;
    int   frame_stamp = 0;
    logic have_stamp = 1'b0;
    int   hs_low_clks = 0;
    logic [9:0] prev_x0 = 10'd0;
    logic       prev_hs0 = 1'b1;
    logic [9:0] prev_x1 = 10'd0, prev_y1 = 10'd0;

    // Per-clk comparison of every output against the model, plus pinned literals
    always @(negedge clk) begin
        cyc++;
        if (run_cmp) begin
            for (int k = 0; k < 2; k++) begin
                int x, y;
                logic [31:0] e, a;
                logic ebusy, eack;
                x = xof(k, m_n[k]);
                y = yof(k, m_n[k]);
                ebusy = m_pend[k];
                eack  = m_ack[k];
                e = {10'(x), 10'(y),
                     !((x >= P_HSS[k]) && (x <= P_HSE[k])),
                     !((y >= P_VSS[k]) && (y <= P_VSE[k])),
                     (m_n[k] >= 2) && visof(k, x, y),
                     cellof(k, x, y),
                     (m_n[k] >= 2) ? m_rgb[k] : 3'b000,
                     ebusy, eack};
                a = {xp[k], yp[k], hs[k], vs[k], von[k], ci[k], rg[k],
                     (k == 0) ? wr0.busy : wr1.busy,
                     (k == 0) ? wr0.wr_ack : wr1.wr_ack};
                chk($sformatf("model_outputs[%0d]", k), a, e);
            end

            // full-timing instance: boundary mapping and hsync shape
            if (yp[0] == 10'd0 && xp[0] == 10'd159) chk("cell_x159_y0", 32'(ci[0]), 32'd0);
            if (yp[0] == 10'd0 && xp[0] == 10'd160) chk("cell_x160_y0", 32'(ci[0]), 32'd1);
            if (yp[0] == 10'd0 && xp[0] == 10'd480) chk("cell_x480_y0", 32'(ci[0]), 32'd3);
            if (yp[0] == 10'd0 && xp[0] == 10'd640) begin
                chk("video_on_x640", 32'(von[0]), 32'd0);
                chk("rgb_x640", 32'(rg[0]), 32'd0);
            end
            if (prev_hs0 && !hs[0]) chk("hsync_fall_x", 32'(xp[0]), 32'd656);
            if (!hs[0]) hs_low_clks++;
            if (prev_x0 == 10'd799 && xp[0] == 10'd0) begin
                chk("hsync_low_clks_per_line", 32'(hs_low_clks), 32'd192);
                hs_low_clks = 0;
            end

            // shrunken instance: last cell, vsync lines, frame length
            if (xp[1] == 10'd15 && yp[1] == 10'd11) chk("cell_last", 32'(ci[1]), 32'd15);
            if (xp[1] == 10'd0 && yp[1] == 10'd14) chk("vsync_line14", 32'(vs[1]), 32'd0);
            if (xp[1] == 10'd0 && yp[1] == 10'd13) chk("vsync_line13", 32'(vs[1]), 32'd1);
            if (rst[1]) begin
                have_stamp = 1'b0;
            end else if (xp[1] == 10'd0 && yp[1] == 10'd0 &&
                         (prev_x1 != 10'd0 || prev_y1 != 10'd0)) begin
                if (have_stamp) chk("frame_clks", 32'(cyc - frame_stamp), 32'd952);
                frame_stamp = cyc;
                have_stamp  = 1'b1;
            end
        end
        prev_x0  = xp[0];
        prev_hs0 = hs[0];
        prev_x1  = xp[1];
        prev_y1  = yp[1];
    end

    // ---------------- stimulus ----------------
    task automatic wait_xy(input int x, input int y, input string nm);
        int c;
        c = 0;
        while (!(int'(xp[1]) == x && int'(yp[1]) == y) && c < 2000) begin
            @(negedge clk);
            c++;
        end
        if (c >= 2000) chk({nm, "_timeout"}, 32'd1, 32'd0);
    endtask

    task automatic wait_ack(input string nm);
        int c;
        c = 0;
        while (!wr1.wr_ack && c < 3000) begin
            @(negedge clk);
            c++;
        end
        if (!wr1.wr_ack) chk({nm, "_ack_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic do_write(input logic [3:0] a, input logic [2:0] col);
        @(posedge clk); #1;
        wr1.wr_req = 1'b1; wr1.wr_addr = a; wr1.wr_color = col;
        wait_ack("fill");
        @(posedge clk); #1;
        wr1.wr_req = 1'b0;
    endtask

    initial begin
        repeat (95000) @(posedge clk);
        chk("watchdog_finished", 32'd0, 32'd1);
        summary();
        $finish;
    end

    initial begin
        int c;
        rst = 2'b11;
        wr0.wr_req = 1'b0; wr0.wr_addr = 4'd0; wr0.wr_color = 3'b000;
        wr1.wr_req = 1'b0; wr1.wr_addr = 4'd0; wr1.wr_color = 3'b000;
        repeat (3) @(posedge clk);
        #1;
        // reset state
        chk("rst_x", 32'(xp[1]), 32'd0);
        chk("rst_y", 32'(yp[1]), 32'd0);
        chk("rst_syncs", 32'({hs[1], vs[1]}), 32'd3);
        chk("rst_video_rgb", 32'({von[1], rg[1]}), 32'd0);
        chk("rst_cell", 32'(ci[1]), 32'd0);
        chk("rst_busy_ack", 32'({wr1.busy, wr1.wr_ack}), 32'd0);
        chk("rst_full_x", 32'(xp[0]), 32'd0);
        run_cmp = 1'b1;
        rst = 2'b00;
        @(posedge clk); #1;
        chk("first_clk_x", 32'(xp[1]), 32'd0);
        chk("first_clk_video", 32'(von[1]), 32'd0);
        @(posedge clk); #1;
        chk("first_adv_x", 32'(xp[1]), 32'd1);
        chk("first_adv_video", 32'(von[1]), 32'd1);

        // write during visible lines is held off until vertical blank
        wait_xy(0, 3, "w5_start");
        @(posedge clk); #1;
        wr1.wr_req = 1'b1; wr1.wr_addr = 4'd5; wr1.wr_color = 3'b100;
        @(posedge clk); #1;
        wr1.wr_addr = 4'd9; wr1.wr_color = 3'b011;
        wait_xy(5, 4, "w5_pix_now");
        chk("w5_pix_this_frame", 32'(rg[1]), 32'd0);
        chk("w5_busy_visible", 32'({wr1.busy, wr1.wr_ack}), 32'd2);
        wait_ack("w5");
        chk("w5_ack_line", 32'(yp[1]), 32'd12);
        chk("w5_busy_with_ack", 32'(wr1.busy), 32'd0);
        @(posedge clk); #1;
        wr1.wr_req = 1'b0;
        wait_xy(5, 4, "w5_pix_next");
        chk("w5_pix_next_frame", 32'(rg[1]), 32'd4);

        // request already inside vertical blank commits on the next clk
        wait_xy(0, 14, "vb_start");
        @(posedge clk); #1;
        wr1.wr_req = 1'b1; wr1.wr_addr = 4'd2; wr1.wr_color = 3'b001;
        c = 0;
        while (!wr1.wr_ack && c < 10) begin
            @(posedge clk); #1;
            c++;
        end
        chk("vb_ack_clks", 32'(c), 32'd2);
        chk("vb_busy_with_ack", 32'(wr1.busy), 32'd0);
        wr1.wr_req = 1'b0;

        // reset while waiting for blank drops the write and clears colours
        wait_xy(0, 2, "rst_mid_start");
        @(posedge clk); #1;
        wr1.wr_req = 1'b1; wr1.wr_addr = 4'd7; wr1.wr_color = 3'b101;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_mid_busy_before", 32'(wr1.busy), 32'd1);
        rst[1] = 1'b1;
        wr1.wr_req = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_mid_busy_ack", 32'({wr1.busy, wr1.wr_ack}), 32'd0);
        chk("rst_mid_xy", 32'({xp[1], yp[1]}), 32'd0);
        rst[1] = 1'b0;
        wait_xy(5, 4, "rst_mid_pix5");
        chk("rst_mid_colour5_cleared", 32'(rg[1]), 32'd0);
        wait_xy(0, 13, "rst_mid_blank");
        wait_xy(13, 4, "rst_mid_pix7");
        chk("rst_mid_colour7_dropped", 32'(rg[1]), 32'd0);

        // all cells green, then check a column-boundary pixel and an interior one
        for (int a = 0; a < 16; a++) do_write(4'(a), 3'b010);
        wait_xy(4, 1, "border_pix");
        chk("border_x4_y1", 32'(rg[1]), 32'(C_BORDER_EXP));
        wait_xy(5, 1, "inner_pix");
        chk("inner_x5_y1", 32'(rg[1]), 32'd2);

        // randomized writes, with address/colour churn while busy
        repeat (30) begin
            repeat ($urandom_range(0, 300)) @(posedge clk);
            #1;
            wr1.wr_req   = 1'b1;
            wr1.wr_addr  = 4'($urandom);
            wr1.wr_color = 3'($urandom);
            c = 0;
            while (!wr1.wr_ack && c < 3000) begin
                @(posedge clk); #1;
                c++;
                if (wr1.busy && $urandom_range(0, 3) == 0) begin
                    wr1.wr_addr  = 4'($urandom);
                    wr1.wr_color = 3'($urandom);
                end
            end
            if (!wr1.wr_ack) chk("rand_ack_timeout", 32'd0, 32'd1);
            wr1.wr_req = 1'b0;
        end

        repeat (1000) @(posedge clk);
        summary();
        $finish;
    end

endmodule
`default_nettype wire
